// File: rtl/mm_link_pkg.sv
// Shared types and helpers for the multiplier link controller:
// FSM state encoding, default frame header and byte-counter sizing.
package mm_link_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RX_X,
        RX_Y,
        WAIT_START,
        MM_RUN,
        TX_Q
    } mm_state_t;

    localparam logic [7:0] MM_HDR_DEFAULT = 8'hA5;

    // Counter must hold 0 .. WIDTH/8-1 with headroom for the increment.
    function automatic int byte_cnt_w(input int width);
        return $clog2(width / 8) + 1;
    endfunction

endpackage

// File: rtl/mm_byte_shifter.sv
// WIDTH-bit operand register with parallel load, byte shift-in at the top
// (LSB-first reception) and byte shift-out toward bit 0 (LSB-first transmit).
module mm_byte_shifter #(
    parameter int WIDTH = 256
) (
    input  logic             clock,
    input  logic             reset_all_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_in,
    input  logic [7:0]       byte_in,
    input  logic             shift_out,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clock or negedge reset_all_n) begin
        if (!reset_all_n) begin
            data <= '0;
        end else if (load) begin
            data <= load_data;
        end else if (shift_in) begin
            data <= {byte_in, data[WIDTH-1:8]};
        end else if (shift_out) begin
            data <= {8'h00, data[WIDTH-1:8]};
        end
    end

endmodule

// File: rtl/mm_link_ctrl.sv
// Byte-serial front end for a Montgomery multiplier: receives a framed X/Y
// operand pair, launches the multiplier and streams the result back out.
//
// state      | meaning
// IDLE       | hunting for the header byte, other bytes dropped
// RX_X       | collecting WIDTH/8 bytes of X, LSB first
// RX_Y       | collecting WIDTH/8 bytes of Y, LSB first
// WAIT_START | operands complete, waiting for start_MM (manual launch only)
// MM_RUN     | multiplier running, waiting for mm_done
// TX_Q       | streaming WIDTH/8 result bytes, LSB first
module mm_link_ctrl
    import mm_link_pkg::*;
#(
    parameter int         WIDTH       = 256,
    parameter int         AUTO_START  = 1,
    parameter int         TIMEOUT_CYC = 1_000_000,
    parameter logic [7:0] HDR         = MM_HDR_DEFAULT
) (
    input  logic             clock,
    input  logic             reset_all_n,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    input  logic             start_MM,
    output logic [WIDTH-1:0] mm_X,
    output logic [WIDTH-1:0] mm_Y,
    output logic             mm_start,
    input  logic [WIDTH-1:0] mm_Q,
    input  logic             mm_done,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic             Rx_done,
    output logic             Tx_done,
    output logic             err
);

    localparam int NB = WIDTH / 8;
    localparam int CW = byte_cnt_w(WIDTH);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CW-1:0] LAST_IDX = CW'(NB - 1);
    // Loaded on each byte; terminal count 0 lands exactly TIMEOUT_CYC cycles later.
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYC - 1);

    mm_state_t         state;
    mm_state_t         state_next;
    logic [CW-1:0]     byte_cnt;
    logic [TW-1:0]     tmr;
    logic              mm_start_q;
    logic              in_rx;
    logic              last_byte;
    logic              timeout;
    logic              tx_accept;
    logic [WIDTH-1:0]  q_data;
    logic [WIDTH-9:0]  q_hi_unused;

    assign in_rx     = (state == RX_X) || (state == RX_Y);
    assign last_byte = (byte_cnt == LAST_IDX);
    assign timeout   = in_rx && !rx_valid && (tmr == '0);
    assign tx_accept = (state == TX_Q) && tx_ready;

    always_comb begin
        state_next = state;
        Rx_done    = 1'b0;
        Tx_done    = 1'b0;
        err        = timeout;
        case (state)
            IDLE: begin
                if (rx_valid && (rx_data == HDR)) state_next = RX_X;
            end
            RX_X: begin
                if (timeout)                      state_next = IDLE;
                else if (rx_valid && last_byte)   state_next = RX_Y;
            end
            RX_Y: begin
                if (timeout) begin
                    state_next = IDLE;
                end else if (rx_valid && last_byte) begin
                    Rx_done    = 1'b1;
                    state_next = (AUTO_START != 0) ? MM_RUN : WAIT_START;
                end
            end
            WAIT_START: begin
                if (start_MM) state_next = MM_RUN;
            end
            MM_RUN: begin
                if (mm_done) state_next = TX_Q;
            end
            TX_Q: begin
                if (tx_ready && last_byte) begin
                    Tx_done    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_all_n) begin
        if (!reset_all_n) begin
            state      <= IDLE;
            byte_cnt   <= '0;
            tmr        <= '0;
            mm_start_q <= 1'b0;
        end else begin
            state      <= state_next;
            mm_start_q <= (state_next == MM_RUN) && (state != MM_RUN);

            if (state_next != state)
                byte_cnt <= '0;
            else if ((in_rx && rx_valid) || tx_accept)
                byte_cnt <= byte_cnt + 1'b1;

            if (!in_rx || rx_valid)
                tmr <= TMR_LOAD;
            else if (tmr != '0)
                tmr <= tmr - 1'b1;
        end
    end

    mm_byte_shifter #(.WIDTH(WIDTH)) u_x (
        .clock      (clock),
        .reset_all_n(reset_all_n),
        .load       (1'b0),
        .load_data  ('0),
        .shift_in   ((state == RX_X) && rx_valid),
        .byte_in    (rx_data),
        .shift_out  (1'b0),
        .data       (mm_X)
    );

    mm_byte_shifter #(.WIDTH(WIDTH)) u_y (
        .clock      (clock),
        .reset_all_n(reset_all_n),
        .load       (1'b0),
        .load_data  ('0),
        .shift_in   ((state == RX_Y) && rx_valid),
        .byte_in    (rx_data),
        .shift_out  (1'b0),
        .data       (mm_Y)
    );

    mm_byte_shifter #(.WIDTH(WIDTH)) u_q (
        .clock      (clock),
        .reset_all_n(reset_all_n),
        .load       ((state == MM_RUN) && mm_done),
        .load_data  (mm_Q),
        .shift_in   (1'b0),
        .byte_in    (8'h00),
        .shift_out  (tx_accept),
        .data       (q_data)
    );

    assign {q_hi_unused, tx_data} = q_data;
    assign tx_valid = (state == TX_Q);
    assign busy     = (state != IDLE);
    assign mm_start = mm_start_q;

endmodule

// File: tb/tb_mm_link_ctrl.sv
// Randomized self-checking bench: one auto-launch and one manual-launch
// instance share stimulus; expectations come from frame-level arithmetic.
module tb_mm_link_ctrl;

    localparam int W  = 16;
    localparam int NB = W / 8;
    localparam int TO = 100;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          start_MM = 1'b0;
    logic [W-1:0]  mm_Q = '0;
    logic          mm_done = 1'b0;
    logic          tx_ready = 1'b0;

    logic [W-1:0]  a_mm_X, a_mm_Y, m_mm_X, m_mm_Y;
    logic [7:0]    a_tx_data, m_tx_data;
    logic          a_mm_start, a_tx_valid, a_busy, a_rx_done, a_tx_done, a_err;
    logic          m_mm_start, m_tx_valid, m_busy, m_rx_done, m_tx_done, m_err;

    mm_link_ctrl #(.WIDTH(W), .AUTO_START(1), .TIMEOUT_CYC(TO), .HDR(8'hA5)) dut_a (
        .clock(clk), .reset_all_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .start_MM(start_MM), .mm_X(a_mm_X), .mm_Y(a_mm_Y), .mm_start(a_mm_start),
        .mm_Q(mm_Q), .mm_done(mm_done), .tx_data(a_tx_data), .tx_valid(a_tx_valid),
        .tx_ready(tx_ready), .busy(a_busy), .Rx_done(a_rx_done), .Tx_done(a_tx_done),
        .err(a_err)
    );

    mm_link_ctrl #(.WIDTH(W), .AUTO_START(0), .TIMEOUT_CYC(TO), .HDR(8'hA5)) dut_m (
        .clock(clk), .reset_all_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .start_MM(start_MM), .mm_X(m_mm_X), .mm_Y(m_mm_Y), .mm_start(m_mm_start),
        .mm_Q(mm_Q), .mm_done(mm_done), .tx_data(m_tx_data), .tx_valid(m_tx_valid),
        .tx_ready(tx_ready), .busy(m_busy), .Rx_done(m_rx_done), .Tx_done(m_tx_done),
        .err(m_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Event monitor, sampled mid-cycle
    int a_rxd_n = 0, a_rxd_cyc = 0, a_st_n = 0, a_st_cyc = 0, a_txd_n = 0, a_txd_cyc = 0;
    int a_err_n = 0, a_err_cyc = 0;
    int m_rxd_n = 0, m_rxd_cyc = 0, m_st_n = 0, m_st_cyc = 0, m_txd_n = 0, m_txd_cyc = 0;
    int m_err_n = 0, m_err_cyc = 0;
    logic [7:0] a_txq[$];
    logic [7:0] m_txq[$];
    logic       a_hold = 1'b0;
    logic [7:0] a_hold_data = '0;

    always @(negedge clk) begin
        if (a_rx_done)  begin a_rxd_n++; a_rxd_cyc = cyc; end
        if (a_mm_start) begin a_st_n++;  a_st_cyc  = cyc; end
        if (a_tx_done)  begin a_txd_n++; a_txd_cyc = cyc; end
        if (a_err)      begin a_err_n++; a_err_cyc = cyc; end
        if (m_rx_done)  begin m_rxd_n++; m_rxd_cyc = cyc; end
        if (m_mm_start) begin m_st_n++;  m_st_cyc  = cyc; end
        if (m_tx_done)  begin m_txd_n++; m_txd_cyc = cyc; end
        if (m_err)      begin m_err_n++; m_err_cyc = cyc; end
        if (a_hold) chk("tx_stall_hold", {a_tx_valid, a_tx_data}, {1'b1, a_hold_data});
        a_hold      = a_tx_valid && !tx_ready;
        a_hold_data = a_tx_data;
        if (a_tx_valid && tx_ready) a_txq.push_back(a_tx_data);
        if (m_tx_valid && tx_ready) m_txq.push_back(m_tx_data);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, output int c);
        rx_data  = b;
        rx_valid = 1'b1;
        c        = cyc;
        step(1);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic run_frame(input logic [W-1:0] x, input logic [W-1:0] y,
                             input logic [W-1:0] q, input int gap_max, input int junk,
                             input int hold, input bit rdy_rand, input int stall,
                             input int long_gap);
        int c, ylast, s0, d, ra, sa, sm, ta, tm, ea, budget, stall_left;
        logic [7:0] b;
        repeat (junk) begin
            b = 8'($urandom);
            if (b == 8'hA5) b = 8'h5A;
            send(b, c);
            step($urandom_range(0, 2));
        end
        if (junk > 0) chk("idle_after_junk", {a_busy, m_busy}, 0);
        ra = a_rxd_n; sa = a_st_n; sm = m_st_n; ta = a_txd_n; tm = m_txd_n; ea = a_err_n;
        send(8'hA5, c);
        for (int i = 0; i < 2 * NB; i++) begin
            if (i == 1) step(long_gap);
            else        step($urandom_range(0, gap_max));
            if (i < NB) b = x[8*i +: 8];
            else        b = y[8*(i-NB) +: 8];
            send(b, c);
        end
        ylast = c;
        step(1);
        chk("no_err_in_frame", a_err_n - ea, 0);
        chk("rx_done_cnt", a_rxd_n - ra, 1);
        chk("rx_done_cyc", a_rxd_cyc, ylast);
        chk("man_rx_done_cyc", m_rxd_cyc, ylast);
        chk("auto_start_cnt", a_st_n - sa, 1);
        chk("auto_start_lat", a_st_cyc, ylast + 1);
        chk("man_no_start_yet", m_st_n - sm, 0);
        chk("man_wait_busy", m_busy, 1);
        repeat (2) begin
            b = ($urandom % 2 != 0) ? 8'hA5 : 8'($urandom);
            send(b, c);
        end
        chk("x_auto", a_mm_X, x);
        chk("y_auto", a_mm_Y, y);
        chk("x_man", m_mm_X, x);
        chk("y_man", m_mm_Y, y);
        chk("no_tx_in_run", {a_tx_valid, a_busy}, 2'b01);
        start_MM = 1'b1;
        s0 = cyc;
        step(hold);
        start_MM = 1'b0;
        step(1);
        chk("man_start_cnt", m_st_n - sm, 1);
        chk("man_start_cyc", m_st_cyc, s0 + 1);
        chk("auto_start_once", a_st_n - sa, 1);
        mm_Q    = q;
        mm_done = 1'b1;
        d       = cyc;
        step(1);
        mm_done = 1'b0;
        mm_Q    = W'($urandom);
        budget  = 0;
        stall_left = stall;
        while ((a_txd_n == ta || m_txd_n == tm) && budget < 300) begin
            if (stall_left > 0) begin
                tx_ready = 1'b0;
                stall_left--;
            end else begin
                tx_ready = rdy_rand ? 1'($urandom % 2) : 1'b1;
            end
            step(1);
            budget++;
        end
        chk("tx_wait_bound", budget < 300, 1);
        chk("tx_done_cnt", a_txd_n - ta, 1);
        chk("man_tx_done_cnt", m_txd_n - tm, 1);
        if (!rdy_rand && stall == 0) chk("tx_done_cyc", a_txd_cyc, d + NB);
        chk("tx_len", a_txq.size(), NB);
        chk("man_tx_len", m_txq.size(), NB);
        for (int i = 0; i < NB; i++) begin
            if (a_txq.size() > 0) chk("tx_byte", a_txq.pop_front(), 8'(q >> (8*i)));
            if (m_txq.size() > 0) chk("man_tx_byte", m_txq.pop_front(), 8'(q >> (8*i)));
        end
        a_txq.delete();
        m_txq.delete();
        chk("idle_after_tx", {a_busy, a_tx_valid, m_busy, m_tx_valid}, 0);
        tx_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c, b34, ea, em, budget, sa, sm;
        logic [7:0] b;

        step(3);
        chk("reset_outputs_a", {a_mm_X, a_mm_Y, a_tx_data, a_tx_valid, a_busy, a_mm_start,
                                a_rx_done, a_tx_done, a_err}, 0);
        chk("reset_outputs_m", {m_mm_X, m_mm_Y, m_tx_data, m_tx_valid, m_busy, m_mm_start,
                                m_rx_done, m_tx_done, m_err}, 0);
        rst_n = 1'b1;
        step(2);

        // Documented example frame, result BEEF
        run_frame(16'h1234, 16'h5678, 16'hBEEF, 0, 0, 5, 1'b0, 0, 0);
        // Transmitter back-pressure
        run_frame(W'($urandom), W'($urandom), W'($urandom), 3, 1, 2, 1'b0, 20, 0);
        // Longest legal inter-byte gap
        run_frame(W'($urandom), W'($urandom), W'($urandom), 2, 0, 1, 1'b1, 0, TO - 1);

        for (int k = 0; k < 8; k++)
            run_frame(W'($urandom), W'($urandom), W'($urandom), 4, $urandom_range(0, 3),
                      $urandom_range(1, 4), 1'b1, $urandom_range(0, 3), 0);

        // Inter-byte timeout
        ea = a_err_n; em = m_err_n;
        send(8'hA5, c);
        send(8'h34, c);
        b34 = c;
        budget = 0;
        while (a_err_n == ea && budget < 150) begin
            step(1);
            budget++;
        end
        step(1);
        chk("err_wait_bound", budget < 150, 1);
        chk("err_cnt", a_err_n - ea, 1);
        chk("err_cyc", a_err_cyc, b34 + TO);
        chk("man_err_cyc", m_err_cyc, b34 + TO);
        chk("man_err_cnt", m_err_n - em, 1);
        chk("idle_after_err", {a_busy, m_busy}, 0);
        send(8'h11, c);
        step(1);
        chk("discard_after_err", {a_busy, m_busy}, 0);
        run_frame(W'($urandom), W'($urandom), W'($urandom), 2, 0, 1, 1'b1, 0, 0);

        // Reset during Y reception, then a stray mm_done
        send(8'hA5, c);
        for (int i = 0; i < NB + 1; i++) send(8'($urandom), c);
        rst_n = 1'b0;
        #1;
        chk("midframe_reset_a", {a_mm_X, a_mm_Y, a_tx_data, a_tx_valid, a_busy, a_mm_start,
                                 a_rx_done, a_tx_done, a_err}, 0);
        step(3);
        rst_n = 1'b1;
        step(1);
        sa = a_st_n; sm = m_st_n;
        mm_Q = W'($urandom);
        mm_done = 1'b1;
        tx_ready = 1'b1;
        step(1);
        mm_done = 1'b0;
        step(10);
        chk("late_done_no_start", (a_st_n - sa) + (m_st_n - sm), 0);
        chk("late_done_outputs", {a_mm_X, a_mm_Y, a_tx_data, a_tx_valid, a_busy,
                                  m_tx_valid, m_busy}, 0);
        chk("late_done_no_tx", a_txq.size() + m_txq.size(), 0);
        tx_ready = 1'b0;

        // start_MM and mm_done together while waiting for manual launch
        send(8'hA5, c);
        for (int i = 0; i < 2 * NB; i++) send(8'($urandom), c);
        step(2);
        sm = m_st_n;
        start_MM = 1'b1;
        mm_done  = 1'b1;
        mm_Q     = W'($urandom);
        b        = 8'(cyc);
        step(1);
        start_MM = 1'b0;
        mm_done  = 1'b0;
        tx_ready = 1'b1;
        step(3);
        chk("coincide_start_cnt", m_st_n - sm, 1);
        chk("coincide_start_cyc", 8'(m_st_cyc), b + 8'd1);
        chk("coincide_done_ignored", {m_busy, m_tx_valid}, 2'b10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mm_link_ctrl.md
MM_LINK_CTRL -- requirements
Module: mm_link_ctrl

Interface
REQ-001 Parameter WIDTH, default 256, operand/result width in bits; SHALL be a multiple of 8 and at least 16.
REQ-002 Parameter AUTO_START, default 1: 1 launches the multiplier as soon as Y is complete; 0 waits for start_MM.
REQ-003 Parameter TIMEOUT_CYC, default 1_000_000, maximum clock cycles allowed between received bytes inside a frame.
REQ-004 Parameter HDR, default 8'hA5, frame header byte.
REQ-005 Ports SHALL be as follows; one clock; reset is asynchronous and active-low:
- clock  in  1  system clock, all logic on rising edge
- reset_all_n  in  1  asynchronous active-low reset
- rx_data  in  8  received byte from the UART receiver
- rx_valid  in  1  one-cycle strobe, rx_data valid
- start_MM  in  1  manual launch request, used only when AUTO_START=0
- mm_X  out  WIDTH  operand X to the multiplier
- mm_Y  out  WIDTH  operand Y to the multiplier
- mm_start  out  1  one-cycle multiplier launch pulse
- mm_Q  in  WIDTH  multiplier result
- mm_done  in  1  multiplier completion strobe
- tx_data  out  8  byte to the UART transmitter
- tx_valid  out  1  tx_data valid, held until accepted
- tx_ready  in  1  transmitter can accept a byte
- busy  out  1  high in every state except IDLE
- Rx_done  out  1  one-cycle pulse when Y is complete
- Tx_done  out  1  one-cycle pulse when the last Q byte is accepted
- err  out  1  one-cycle pulse on an inter-byte timeout

Function
REQ-006 The FSM states SHALL be IDLE, RX_X, RX_Y, WAIT_START, MM_RUN, TX_Q.
REQ-007 IDLE: a rx_valid with rx_data==HDR SHALL move the FSM to RX_X; any other byte SHALL be discarded.
REQ-008 RX_X and RX_Y SHALL each accept WIDTH/8 bytes, least-significant byte first, into mm_X and mm_Y respectively.
REQ-009 The byte counter SHALL clear on every state entry, and the state SHALL advance on the cycle after the last byte.
REQ-010 Completion of Y SHALL pulse Rx_done and go to MM_RUN, pulsing mm_start on the entry cycle (AUTO_START=1), or go to WAIT_START (AUTO_START=0).
REQ-011 WAIT_START: start_MM high SHALL pulse mm_start for exactly one cycle and go to MM_RUN; rx bytes in WAIT_START SHALL be ignored.
REQ-012 mm_X and mm_Y SHALL stay stable from Rx_done until the next frame's first operand byte.
REQ-013 MM_RUN: on mm_done the block SHALL capture mm_Q into an internal shift register and enter TX_Q; mm_done in any other state SHALL be ignored.
REQ-014 TX_Q: WIDTH/8 bytes, least-significant byte first; tx_valid high with tx_data stable until the cycle tx_valid&&tx_ready, then the next byte is presented on the following cycle.
REQ-015 Acceptance of the last byte SHALL pulse Tx_done, deassert tx_valid and return to IDLE.
REQ-016 The inter-byte counter SHALL run only in RX_X and RX_Y and reload on each rx_valid.
REQ-017 When the counter reaches TIMEOUT_CYC, the block SHALL pulse err and return to IDLE; mm_X and mm_Y keep their partial contents.
REQ-018 rx_valid in MM_RUN or TX_Q SHALL be dropped, with no effect on state or operands.
REQ-019 If mm_done and start_MM coincide in WAIT_START, start_MM SHALL win and mm_done is ignored.
REQ-020 The end-to-end latency from the last Y byte to mm_start (AUTO_START=1) SHALL be exactly 1 cycle.

Reset
REQ-021 While reset_all_n is low, the FSM SHALL be IDLE, and mm_X, mm_Y, the Q register, tx_data and all counters SHALL be zero.
REQ-022 While reset_all_n is low, mm_start, tx_valid, busy, Rx_done, Tx_done and err SHALL be 0.
REQ-023 Reset asserted mid-frame or mid-transmit SHALL abort immediately; an mm_done after reset release SHALL be ignored (FSM in IDLE).

Structure
REQ-024 The state enum, HDR default and the byte-count width function ($clog2(WIDTH/8)+1) SHALL live in the shared package mm_link_pkg.
REQ-025 One sub-module, mm_byte_shifter (parametrised WIDTH, load/shift-in/shift-out), SHALL be instantiated three times: X, Y, Q.

Verification
REQ-026 WIDTH=16, AUTO_START=1: bytes A5,34,12,78,56 -> mm_X=16'h1234, mm_Y=16'h5678, Rx_done then mm_start 1 cycle after byte 56.
REQ-027 After REQ-026, mm_done with mm_Q=16'hBEEF, tx_ready=1 -> tx_data EF then BE, Tx_done on BE acceptance, busy low next cycle.
REQ-028 AUTO_START=0: full frame then start_MM held 5 cycles -> exactly one mm_start pulse.
REQ-029 TIMEOUT_CYC=100: A5,34 then silence -> err pulse 100 cycles after byte 34, FSM IDLE, next byte 11 discarded.
REQ-030 tx_ready low 20 cycles during TX_Q -> tx_data/tx_valid stable throughout; rx bytes during MM_RUN change nothing.
REQ-031 reset_all_n low during RX_Y, then a late mm_done -> all outputs zero, no mm_start, no tx_valid.
